// File: rtl/fnd_scan_cntr.sv
// fnd_scan_cntr: time-multiplexed driver for a 4-digit common-anode 7-segment
// display. Scans one digit per SCAN_DIV cycles and keeps all anodes off for
// the first BLANK_CYC cycles of each slot. Digits blink per blink_mask, and
// decimal points come from dp_mask. Each new value is applied only at a
// frame boundary, so a frame never shows a mix of old and new digits.
module fnd_scan_cntr #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic        value_valid,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [7:0]  seg_n,
  output logic [3:0]  com_n
);

  localparam int SCW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
  localparam logic [SCW-1:0] BLANK_MIN  = SCW'(BLANK_CYC);
  localparam logic [BLW-1:0] BLINK_LAST = BLW'(BLINK_DIV - 1);

  logic [SCW-1:0] scan_cnt_q;
  logic [1:0]     idx_q;
  logic [BLW-1:0] blink_cnt_q;
  logic           blink_phase_q;
  logic [15:0]    hold_q;
  logic [15:0]    disp_q;
  logic           pending_q;
  logic [7:0]     seg_n_q, seg_n_d;
  logic [3:0]     com_n_q, com_n_d;

  logic           slot_end;
  logic           frame_end;
  logic [3:0]     digit;

  assign slot_end  = (scan_cnt_q == SCAN_LAST);
  assign frame_end = slot_end && (idx_q == 2'd3);
  assign digit     = disp_q[{idx_q, 2'b00} +: 4];

  // Slot timer and digit index; idx wraps naturally from 3 to 0.
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else if (slot_end) begin
      scan_cnt_q <= '0;
      idx_q      <= idx_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + SCW'(1);
    end
  end

  // Free-running blink timebase, independent of scan and enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + BLW'(1);
    end
  end

  // Value capture: stage into hold, publish to disp only at a frame boundary.
  // A strobe landing on the boundary itself goes straight to disp.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q    <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
    end else if (value_valid) begin
      hold_q <= value;
      if (frame_end) begin
        disp_q    <= value;
        pending_q <= 1'b0;
      end else begin
        pending_q <= 1'b1;
      end
    end else if (frame_end && pending_q) begin
      disp_q    <= hold_q;
      pending_q <= 1'b0;
    end
  end

  // Segment decode and anode select for the current slot.
  // NOTE: outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    seg_n_d = 8'hFF;
    com_n_d = 4'hF;
    case (digit)
      4'd0:    seg_n_d[6:0] = 7'b1000000;
      4'd1:    seg_n_d[6:0] = 7'b1111001;
      4'd2:    seg_n_d[6:0] = 7'b0100100;
      4'd3:    seg_n_d[6:0] = 7'b0110000;
      4'd4:    seg_n_d[6:0] = 7'b0011001;
      4'd5:    seg_n_d[6:0] = 7'b0010010;
      4'd6:    seg_n_d[6:0] = 7'b0000010;
      4'd7:    seg_n_d[6:0] = 7'b1111000;
      4'd8:    seg_n_d[6:0] = 7'b0000000;
      4'd9:    seg_n_d[6:0] = 7'b0010000;
      4'd15:   seg_n_d[6:0] = 7'b0111111;
      default: seg_n_d[6:0] = 7'b1111111;
    endcase
    seg_n_d[7] = ~dp_mask[idx_q];
    if (enable && (scan_cnt_q >= BLANK_MIN) && !(blink_phase_q && blink_mask[idx_q])) begin
      com_n_d = ~(4'b0001 << idx_q);
    end
  end

  // Output registers: one cycle of latency, all dark during reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_n_q <= 8'hFF;
      com_n_q <= 4'hF;
    end else begin
      seg_n_q <= seg_n_d;
      com_n_q <= com_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign com_n = com_n_q;

endmodule

// File: doc/fnd_scan_cntr.md
Name: fnd_scan_cntr

Overview:
- Downstream display stage of the multifunction watch. Takes four BCD digits from the time/stopwatch/timer counters and drives the Basys3 4-digit common-anode 7-segment display by time-multiplexing.
- Three more display features:
  - Per-digit blinking, used to show which field is being set.
  - Per-digit decimal points.
  - Frame-synchronous value update, so a digit never tears mid-frame.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Must be ≥ 2.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off, for anti-ghosting. Must be < SCAN_DIV.
- BLINK_DIV, 50000000: clk cycles per blink phase toggle (1 Hz blink at 100 MHz).

Ports:
- clk  in  1: system clock. This is the block's one clock.
- reset_n  in  1: reset. Synchronous, active-low.
- enable  in  1: 1 = display on; 0 = all anodes off.
- value  in  16: four BCD digits. [3:0] is the rightmost digit (digit 0); [15:12] is the leftmost (digit 3).
- value_valid  in  1: single-cycle strobe that captures value.
- blink_mask  in  4: bit i = 1 makes digit i blink.
- dp_mask  in  4: bit i = 1 lights the decimal point of digit i.
- seg_n  out  8: active-low segments. [0]=a … [6]=g, [7]=dp.
- com_n  out  4: active-low anodes. Bit i selects digit i.

Behaviour:
- Reset: when reset_n = 0 at a rising clk edge, the following take these values:
  - scan_cnt = 0, idx = 0
  - blink_cnt = 0, blink_phase = 0
  - hold = 0, disp = 0, pending = 0
  - seg_n = 8'hFF, com_n = 4'hF
- Reset takes priority over every other event. Asserting it mid-frame aborts the frame; the next cycle restarts at slot 0 and count 0.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, scan_cnt wraps to 0 and idx increments. idx is 2 bits and wraps 3→0.
  - The frame boundary is the cycle where scan_cnt = SCAN_DIV-1 and idx = 3.
- Blink counter:
  - blink_cnt counts 0..BLINK_DIV-1.
  - At the terminal count it wraps and blink_phase toggles.
  - It runs independently of scan and enable.
- Value capture:
  - On value_valid = 1, hold ← value and pending ← 1.
  - At a frame boundary with pending = 1, disp ← hold and pending ← 0.
  - If value_valid = 1 on a frame-boundary cycle, disp ← value directly and pending ← 0 (bypass).
  - Consequence: disp changes only between frames. Update latency is at most 4·SCAN_DIV cycles.
- Decode of digit d = disp[4·idx+3 : 4·idx], output as seg_n[6:0]:
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - 15 → 0111111 (minus sign)
  - 10–14 → 1111111 (blank)
- Decimal point: seg_n[7] = ~dp_mask[idx].
- Anode rule: com_n = ~(4'b0001 << idx) only when all of the following hold; otherwise com_n = 4'hF.
  - enable = 1
  - scan_cnt ≥ BLANK_CYC
  - not (blink_phase = 1 and blink_mask[idx] = 1)
- Output timing:
  - seg_n and com_n are registered and reflect the state of the previous cycle (latency 1).
  - seg_n stays decoded even while com_n is off.
- blink_mask and dp_mask are sampled every cycle and are not frame-synchronised.

Test Plan:
- Test parameters for all scenarios: SCAN_DIV = 8, BLANK_CYC = 2, BLINK_DIV = 64.
- Reset and scan order:
  - Stimulus: hold reset_n = 0 for 3 cycles; then strobe value = 16'h1234, enable = 1, blink_mask = 0.
  - Required: seg_n = FF and com_n = F during reset.
  - Required after the first frame boundary, in order:
    - com_n = E with seg_n[6:0] = 0011001 (4)
    - com_n = D with seg_n[6:0] = 0110000 (3)
    - com_n = B with seg_n[6:0] = 0100100 (2)
    - com_n = 7 with seg_n[6:0] = 1111001 (1)
  - Required: each digit slot shows 2 cycles of F followed by 6 cycles active.
- No tearing:
  - Stimulus: strobe value = 16'h5959 while idx = 1; display was 1234.
  - Required: idx 2 and 3 in that frame still show 2 and 1; the next frame shows 9, 5, 9, 5.
- Frame-boundary bypass:
  - Stimulus: value_valid with 16'h0007 on the boundary cycle.
  - Required: the next slot 0 shows 7 (1111000) and pending = 0.
- Blink:
  - Stimulus: blink_mask = 4'b0011.
  - Required: for 64 cycles digits 0–1 are lit as normal; for the next 64 cycles com_n never asserts bits 0 and 1; digits 2–3 are unaffected throughout.
- Special codes and dp:
  - Stimulus: value = 16'hFA00, dp_mask = 4'b0100.
  - Required: digit 3 → 0111111; digit 2 → 1111111 with seg_n[7] = 0; digits 0–1 show 0.
- Enable and mid-frame reset:
  - Stimulus: enable = 0.
  - Required: com_n stays F and idx keeps advancing.
  - Stimulus: reset_n = 0 pulse at idx = 2.
  - Required: idx = 0 and disp = 0 (digit 0 at slot 0 shows 1000000).
